// File: rtl/l2_mem_arbiter.sv
// l2_mem_arbiter: serializes L1I line fills and L1D fills/writebacks onto one
// shared L2 port. L1D wins by default (older instruction in MEM); a starvation
// limiter forces an I grant after STARVE_LIMIT consecutive D grants while I waits.
// Address/data are latched at the grant edge and held for the whole transaction.
// Optional performance counters are built only when ARB_PERF_EN is defined;
// otherwise the counter ports are tied to zero and no counter flops exist.
module l2_mem_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int LINE_WIDTH   = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_resp,
    output logic [LINE_WIDTH-1:0] i_rdata,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic                  d_resp,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  l2_read,
    output logic                  l2_write,
    output logic [ADDR_WIDTH-1:0] l2_addr,
    output logic [LINE_WIDTH-1:0] l2_wdata,
    input  logic                  l2_resp,
    input  logic [LINE_WIDTH-1:0] l2_rdata,
    output logic [15:0]           i_grant_count,
    output logic [15:0]           d_grant_count,
    output logic [15:0]           conflict_count
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D_RD,
        SERVE_D_WR
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    state_t     next_state;
    logic [3:0] starve_cnt;
    logic       grant_i;
    logic       grant_d_rd;
    logic       grant_d_wr;
    logic       grant_d;

    // Read data goes straight through; the resp pulses qualify it.
    assign i_rdata = l2_rdata;
    assign d_rdata = l2_rdata;
    assign grant_d = grant_d_rd | grant_d_wr;

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Arbitration in IDLE, completion in SERVE states, strobes and resp pulses.
    always_comb begin
        next_state = state;
        grant_i    = 1'b0;
        grant_d_rd = 1'b0;
        grant_d_wr = 1'b0;
        l2_read    = 1'b0;
        l2_write   = 1'b0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        case (state)
            IDLE: begin
                if (i_read && (starve_cnt == LIMIT)) begin
                    next_state = SERVE_I;
                    grant_i    = 1'b1;
                end else if (d_write) begin
                    next_state = SERVE_D_WR;
                    grant_d_wr = 1'b1;
                end else if (d_read) begin
                    next_state = SERVE_D_RD;
                    grant_d_rd = 1'b1;
                end else if (i_read) begin
                    next_state = SERVE_I;
                    grant_i    = 1'b1;
                end
            end
            SERVE_I: begin
                l2_read = 1'b1;
                i_resp  = l2_resp;
                if (l2_resp) next_state = IDLE;
            end
            SERVE_D_RD: begin
                l2_read = 1'b1;
                d_resp  = l2_resp;
                if (l2_resp) next_state = IDLE;
            end
            SERVE_D_WR: begin
                l2_write = 1'b1;
                d_resp   = l2_resp;
                if (l2_resp) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Holding registers: capture the winner's address (and writeback data) at the grant edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l2_addr  <= '0;
            l2_wdata <= '0;
        end else begin
            if (grant_i) l2_addr <= i_addr;
            if (grant_d) l2_addr <= d_addr;
            if (grant_d_wr) l2_wdata <= d_wdata;
        end
    end

    // Starvation counter: counts D grants that overtook a waiting I request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d) begin
            if (!i_read) begin
                starve_cnt <= '0;
            end else if (starve_cnt < LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

`ifdef ARB_PERF_EN
    logic [15:0] i_grant_q;
    logic [15:0] d_grant_q;
    logic [15:0] conflict_q;
    logic        conflict;

    assign conflict       = (state == IDLE) && i_read && (d_read || d_write);
    assign i_grant_count  = i_grant_q;
    assign d_grant_count  = d_grant_q;
    assign conflict_count = conflict_q;

    // Saturating performance counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_grant_q  <= '0;
            d_grant_q  <= '0;
            conflict_q <= '0;
        end else begin
            if (grant_i && (i_grant_q != 16'hFFFF)) i_grant_q <= i_grant_q + 16'd1;
            if (grant_d && (d_grant_q != 16'hFFFF)) d_grant_q <= d_grant_q + 16'd1;
            if (conflict && (conflict_q != 16'hFFFF)) conflict_q <= conflict_q + 16'd1;
        end
    end
`else
    assign i_grant_count  = 16'h0000;
    assign d_grant_count  = 16'h0000;
    assign conflict_count = 16'h0000;
`endif

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// tb_l2_mem_arbiter: directed scenarios plus a randomized run checked against a
// transaction-level model of the arbitration rules. Perf expectations follow ARB_PERF_EN.
module tb_l2_mem_arbiter;

    localparam int AW      = 16;
    localparam int LW      = 128;
    localparam int LIMIT   = 4;
    localparam int SIDE_I  = 0;
    localparam int SIDE_DR = 1;
    localparam int SIDE_DW = 2;
`ifdef ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_read = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_resp;
    logic [LW-1:0] i_rdata;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [LW-1:0] d_wdata = '0;
    logic          d_resp;
    logic [LW-1:0] d_rdata;
    logic          l2_read;
    logic          l2_write;
    logic [AW-1:0] l2_addr;
    logic [LW-1:0] l2_wdata;
    logic          l2_resp = 1'b0;
    logic [LW-1:0] l2_rdata = '0;
    logic [15:0]   i_grant_count;
    logic [15:0]   d_grant_count;
    logic [15:0]   conflict_count;

    int checks = 0;
    int fails  = 0;

    // Transaction-level reference model state
    bit            m_busy;
    int            m_side;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    int            m_starve;
    int            m_ig;
    int            m_dg;
    int            m_conf;

    l2_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_addr(i_addr), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
        .l2_resp(l2_resp), .l2_rdata(l2_rdata),
        .i_grant_count(i_grant_count), .d_grant_count(d_grant_count),
        .conflict_count(conflict_count)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [15:0] sat16(input int v);
        return 16'((v > 65535) ? 65535 : v);
    endfunction

    task automatic model_clear();
        m_busy = 1'b0; m_side = SIDE_I; m_addr = '0; m_wdata = '0;
        m_starve = 0; m_ig = 0; m_dg = 0; m_conf = 0;
    endtask

    // Advances the model across one clock edge using the inputs present at that edge.
    task automatic model_edge();
        int win;
        win = -1;
        if (!m_busy) begin
            if (i_read && (d_read || d_write)) m_conf++;
            if (i_read && m_starve == LIMIT) win = SIDE_I;
            else if (d_write) win = SIDE_DW;
            else if (d_read) win = SIDE_DR;
            else if (i_read) win = SIDE_I;
            if (win >= 0) begin
                m_busy = 1'b1;
                m_side = win;
                if (win == SIDE_I) begin
                    m_addr = i_addr; m_starve = 0; m_ig++;
                end else begin
                    m_addr = d_addr; m_dg++;
                    if (!i_read) m_starve = 0;
                    else if (m_starve < LIMIT) m_starve++;
                    if (win == SIDE_DW) m_wdata = d_wdata;
                end
            end
        end else if (l2_resp) begin
            m_busy = 1'b0;
        end
    endtask

    task automatic clear_inputs();
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; l2_resp = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; l2_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        l2_resp = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL reset_strobes: got %b expected 0000", {l2_read, l2_write, i_resp, d_resp});
        end
        checks++;
        if (l2_addr !== '0 || l2_wdata !== '0) begin
            fails++;
            $display("[TB] FAIL reset_holding: got addr=%h wdata=%h expected 0", l2_addr, l2_wdata);
        end
        checks++;
        if ({i_grant_count, d_grant_count, conflict_count} !== 48'h0) begin
            fails++;
            $display("[TB] FAIL reset_perf: got %h/%h/%h expected 0", i_grant_count, d_grant_count, conflict_count);
        end
        l2_resp = 1'b0;
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    task automatic test_i_only();
        int ir = 0;
        int dr = 0;
        do_reset();
        i_read = 1'b1; i_addr = 16'h0040;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            l2_resp  = (c == 4);
            l2_rdata = (c == 4) ? {16{8'hA5}} : '0;
            if (c == 5) i_read = 1'b0;
            #1;
            checks++;
            if (l2_read !== 1'((c >= 1) && (c <= 4)) || l2_write !== 1'b0) begin
                fails++;
                $display("[TB] FAIL ionly_strobe c%0d: got rd=%b wr=%b expected rd=%b wr=0", c, l2_read, l2_write, (c <= 4));
            end
            if (c <= 4) begin
                checks++;
                if (l2_addr !== 16'h0040) begin
                    fails++;
                    $display("[TB] FAIL ionly_addr c%0d: got %h expected 0040", c, l2_addr);
                end
            end
            if (i_resp === 1'b1) begin
                ir++;
                checks++;
                if (i_rdata !== {16{8'hA5}}) begin
                    fails++;
                    $display("[TB] FAIL ionly_rdata: got %h expected a5..a5", i_rdata);
                end
            end
            if (d_resp === 1'b1) dr++;
        end
        checks++;
        if (ir != 1 || dr != 0) begin
            fails++;
            $display("[TB] FAIL ionly_pulses: got i_resp=%0d d_resp=%0d expected 1 and 0", ir, dr);
        end
    endtask

    task automatic test_simultaneous();
        bit exp_rd;
        do_reset();
        i_read = 1'b1; i_addr = 16'h0100;
        d_read = 1'b1; d_addr = 16'h0200;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            l2_resp = (c == 2) || (c == 5);
            if (c == 3) d_read = 1'b0;
            if (c == 6) i_read = 1'b0;
            #1;
            exp_rd = (c == 1) || (c == 2) || (c == 4) || (c == 5);
            checks++;
            if (l2_read !== exp_rd || d_resp !== 1'(c == 2) || i_resp !== 1'(c == 5)) begin
                fails++;
                $display("[TB] FAIL simul_ctrl c%0d: got rd=%b dresp=%b iresp=%b expected rd=%b dresp=%b iresp=%b",
                         c, l2_read, d_resp, i_resp, exp_rd, (c == 2), (c == 5));
            end
            if (exp_rd) begin
                checks++;
                if (l2_addr !== ((c <= 2) ? 16'h0200 : 16'h0100)) begin
                    fails++;
                    $display("[TB] FAIL simul_addr c%0d: got %h expected %h", c, l2_addr, (c <= 2) ? 16'h0200 : 16'h0100);
                end
            end
        end
    endtask

    task automatic test_starvation();
        int  n = 0;
        bit  prev = 1'b0;
        bit  is_i;
        bit  exp_i;
        do_reset();
        i_read = 1'b1; i_addr = 16'h0AA0;
        d_read = 1'b1; d_addr = 16'h0DD0;
        for (int c = 0; c < 200 && n < 2 * (LIMIT + 1); c++) begin
            @(negedge clk);
            l2_resp = l2_read || l2_write;
            #1;
            if (l2_read && !prev) begin
                is_i  = (l2_addr == 16'h0AA0);
                exp_i = ((n % (LIMIT + 1)) == LIMIT);
                checks++;
                if (is_i !== exp_i) begin
                    fails++;
                    $display("[TB] FAIL starve_grant%0d: got side=%s expected %s", n, is_i ? "I" : "D", exp_i ? "I" : "D");
                end
                n++;
            end
            prev = l2_read;
        end
        checks++;
        if (n != 2 * (LIMIT + 1)) begin
            fails++;
            $display("[TB] FAIL starve_timeout: got %0d grants expected %0d", n, 2 * (LIMIT + 1));
        end
        @(negedge clk);
        i_read = 1'b0; d_read = 1'b0; l2_resp = 1'b0;
    endtask

    task automatic test_writeback();
        int dr = 0;
        logic [LW-1:0] wd;
        wd = {4{32'hDEADBEEF}};
        do_reset();
        d_write = 1'b1; d_addr = 16'h1230; d_wdata = wd;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            l2_resp = (c == 4) || (c == 7);
            if (c <= 3 || c == 5) begin
                d_addr = 16'($urandom); d_wdata = rand_line();
            end
            if (c == 5) d_write = 1'b0;
            if (c == 6) begin
                d_read = 1'b1; d_write = 1'b1; d_addr = 16'h0777; d_wdata = '1;
            end
            if (c == 8) begin
                d_read = 1'b0; d_write = 1'b0;
            end
            #1;
            if (d_resp === 1'b1) dr++;
            checks++;
            if (l2_write !== 1'(c <= 4 || c == 7) || l2_read !== 1'b0) begin
                fails++;
                $display("[TB] FAIL wb_strobe c%0d: got wr=%b rd=%b expected wr=%b rd=0", c, l2_write, l2_read, (c <= 4 || c == 7));
            end
            checks++;
            if (c <= 6 && (l2_addr !== 16'h1230 || l2_wdata !== wd)) begin
                fails++;
                $display("[TB] FAIL wb_hold c%0d: got addr=%h wdata=%h expected 1230/%h", c, l2_addr, l2_wdata, wd);
            end else if (c >= 7 && (l2_addr !== 16'h0777 || l2_wdata !== '1)) begin
                fails++;
                $display("[TB] FAIL wb_both c%0d: got addr=%h wdata=%h expected 0777/ff..ff", c, l2_addr, l2_wdata);
            end
        end
        checks++;
        if (dr != 2) begin
            fails++;
            $display("[TB] FAIL wb_dresp: got %0d pulses expected 2", dr);
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        d_read = 1'b1; d_addr = 16'h0300;
        @(negedge clk);
        #1;
        checks++;
        if (l2_read !== 1'b1 || l2_addr !== 16'h0300) begin
            fails++;
            $display("[TB] FAIL midop_start: got rd=%b addr=%h expected 1/0300", l2_read, l2_addr);
        end
        #2;
        rst_n = 1'b0;
        l2_resp = 1'b1;
        #1;
        checks++;
        if (l2_read !== 1'b0 || d_resp !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midop_async: got rd=%b dresp=%b expected 0/0", l2_read, d_resp);
        end
        @(negedge clk);
        d_read = 1'b0; l2_resp = 1'b0;
        rst_n = 1'b1;
        model_clear();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            l2_resp = (c == 1);
            #1;
            checks++;
            if ({l2_read, l2_write, d_resp, i_resp} !== 4'b0000 || l2_addr !== '0 ||
                {i_grant_count, d_grant_count, conflict_count} !== 48'h0) begin
                fails++;
                $display("[TB] FAIL midop_after c%0d: got strobes=%b addr=%h perf=%h/%h/%h expected all 0",
                         c, {l2_read, l2_write, d_resp, i_resp}, l2_addr, i_grant_count, d_grant_count, conflict_count);
            end
        end
    endtask

    task automatic test_perf();
        int ir = 0;
        int dr = 0;
        do_reset();
        for (int p = 0; p < 3; p++) begin
            i_read = 1'b1; i_addr = 16'($urandom);
            d_read = 1'b1; d_addr = 16'($urandom);
            for (int c = 1; c <= 5; c++) begin
                @(negedge clk);
                l2_resp = l2_read || l2_write;
                if (c == 2) d_read = 1'b0;
                if (c == 4) i_read = 1'b0;
                #1;
                if (i_resp === 1'b1) ir++;
                if (d_resp === 1'b1) dr++;
            end
            @(negedge clk);
            l2_resp = 1'b0;
        end
        #1;
        checks++;
        if (ir != 3 || dr != 3) begin
            fails++;
            $display("[TB] FAIL perf_pairs: got i_resp=%0d d_resp=%0d expected 3/3", ir, dr);
        end
        checks++;
        if (conflict_count !== (PERF ? 16'd3 : 16'd0) || d_grant_count !== (PERF ? 16'd3 : 16'd0) ||
            i_grant_count !== (PERF ? 16'd3 : 16'd0)) begin
            fails++;
            $display("[TB] FAIL perf_counts: got conf=%0d d=%0d i=%0d expected %0d each",
                     conflict_count, d_grant_count, i_grant_count, PERF ? 3 : 0);
        end
    endtask

    task automatic test_random();
        int wait_left = -1;
        bit i_done = 1'b0;
        bit d_done = 1'b0;
        bit exp_ir;
        bit exp_dr;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if (i_done) i_read = 1'b0;
            else if (!i_read && $urandom_range(0, 2) == 0) i_read = 1'b1;
            if (d_done) begin
                d_read = 1'b0; d_write = 1'b0;
            end else if (!d_read && !d_write && $urandom_range(0, 1) == 0) begin
                if ($urandom_range(0, 2) == 0) d_write = 1'b1;
                else d_read = 1'b1;
            end
            i_addr = 16'($urandom); d_addr = 16'($urandom);
            d_wdata = rand_line(); l2_rdata = rand_line();
            if (l2_read || l2_write) begin
                if (wait_left < 0) wait_left = $urandom_range(0, 3);
                if (wait_left == 0) begin
                    l2_resp = 1'b1; wait_left = -1;
                end else begin
                    l2_resp = 1'b0; wait_left--;
                end
            end else begin
                l2_resp = ($urandom_range(0, 7) == 0);
                wait_left = -1;
            end
            #1;
            exp_ir = m_busy && l2_resp && (m_side == SIDE_I);
            exp_dr = m_busy && l2_resp && (m_side != SIDE_I);
            checks++;
            if (l2_read !== (m_busy && m_side != SIDE_DW) || l2_write !== (m_busy && m_side == SIDE_DW) ||
                i_resp !== exp_ir || d_resp !== exp_dr) begin
                fails++;
                $display("[TB] FAIL rand_ctrl c%0d: got rd=%b wr=%b ir=%b dr=%b expected rd=%b wr=%b ir=%b dr=%b",
                         c, l2_read, l2_write, i_resp, d_resp,
                         (m_busy && m_side != SIDE_DW), (m_busy && m_side == SIDE_DW), exp_ir, exp_dr);
            end
            checks++;
            if (l2_addr !== m_addr || l2_wdata !== m_wdata) begin
                fails++;
                $display("[TB] FAIL rand_hold c%0d: got addr=%h wdata=%h expected addr=%h wdata=%h",
                         c, l2_addr, l2_wdata, m_addr, m_wdata);
            end
            if (exp_ir || exp_dr) begin
                checks++;
                if ((exp_ir && i_rdata !== l2_rdata) || (exp_dr && d_rdata !== l2_rdata)) begin
                    fails++;
                    $display("[TB] FAIL rand_rdata c%0d: got i=%h d=%h expected %h", c, i_rdata, d_rdata, l2_rdata);
                end
            end
            i_done = exp_ir;
            d_done = exp_dr;
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end
        #1;
        checks++;
        if (i_grant_count !== (PERF ? sat16(m_ig) : 16'd0) || d_grant_count !== (PERF ? sat16(m_dg) : 16'd0) ||
            conflict_count !== (PERF ? sat16(m_conf) : 16'd0)) begin
            fails++;
            $display("[TB] FAIL rand_perf: got i=%0d d=%0d conf=%0d expected i=%0d d=%0d conf=%0d",
                     i_grant_count, d_grant_count, conflict_count,
                     PERF ? m_ig : 0, PERF ? m_dg : 0, PERF ? m_conf : 0);
        end
        clear_inputs();
    endtask

    // Scenario sequence
    initial begin
        $display("[TB] starting l2_mem_arbiter bench, perf=%0d", PERF);
        test_reset();
        test_i_only();
        test_simultaneous();
        test_starvation();
        test_writeback();
        test_reset_midop();
        test_perf();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
